dac_capture_wb: RTL and testbench



---
 rtl/dac_capture_pkg.sv | 22 ++
 rtl/sample_fifo.sv | 63 ++++++
 rtl/dac_capture_wb.sv | 144 ++++++++++++++
 tb/tb_dac_capture_wb.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dac_capture_pkg.sv
// dac_capture_pkg: register map and CTRL/DATA bit positions of the DAC capture FIFO.
`default_nettype none

package dac_capture_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_THRESH = 2'd2;
  localparam logic [1:0] REG_DROPS  = 2'd3;

  // FLUSH is a write-only bit and EMPTY is a read-only bit, so both use position 2.
  localparam int CTRL_EN    = 0;
  localparam int CTRL_OVF   = 1;
  localparam int CTRL_FLUSH = 2;
  localparam int CTRL_EMPTY = 2;
  localparam int CTRL_FULL  = 3;

  localparam int DATA_VALID = 31;

endpackage

`default_nettype wire

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous frame FIFO with asynchronous head read and flush.
`default_nettype none

module sample_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [WIDTH-1:0]      head_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_pop;
  logic                  do_push;

  assign empty     = (level == '0);
  assign full      = (level == (DEPTH_LOG2+1)'(DEPTH));
  assign head_data = mem[rd_ptr];

  // Pop is evaluated first so a full FIFO still accepts a push that coincides with a pop.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) begin
        level <= level + 1'b1;
      end else if (do_pop && !do_push) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dac_capture_wb.sv
// dac_capture_wb: Wishbone-readable capture FIFO for decoded multi-channel DAC frames.
`default_nettype none

module dac_capture_wb
  import dac_capture_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int SAMPLE_W   = 16,
  parameter int DEPTH_LOG2 = 6,
  parameter int DW         = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pcm_valid,
  input  logic [CHANNELS*SAMPLE_W-1:0] pcm_data,
  input  logic [1:0]                   wb_addr,
  input  logic [DW-1:0]                wb_wdata,
  input  logic                         wb_we,
  input  logic                         wb_cyc,
  output logic [DW-1:0]                wb_rdata,
  output logic                         wb_ack,
  output logic                         irq
);

  localparam int FRAME_W = CHANNELS * SAMPLE_W;

  logic                       enable;
  logic                       overflow;
  logic [DEPTH_LOG2:0]        thresh;
  logic [15:0]                drops;
  logic [3:0]                 ch_idx;

  logic [FRAME_W-1:0]         head_data;
  logic [DEPTH_LOG2:0]        level;
  logic                       full;
  logic                       empty;

  logic                       access;
  logic                       ctrl_wr;
  logic                       flush;
  logic                       clear_ovf;
  logic                       data_rd;
  logic                       last_ch;
  logic                       pop;
  logic                       push_req;
  logic                       drop;
  logic signed [SAMPLE_W-1:0] sample;
  logic [23:0]                sample_ext;
  logic [DW-1:0]              rdata_next;
  logic                       unused_wdata;

  assign unused_wdata = &{1'b0, wb_wdata};

  // Side effects only on the first cycle of an access, so a held cyc acts once.
  assign access    = wb_cyc && !wb_ack;
  assign ctrl_wr   = access && wb_we && (wb_addr == REG_CTRL);
  assign flush     = ctrl_wr && wb_wdata[CTRL_FLUSH];
  assign clear_ovf = ctrl_wr && wb_wdata[CTRL_OVF];
  assign data_rd   = access && !wb_we && (wb_addr == REG_DATA) && !empty;
  assign last_ch   = (ch_idx == 4'(CHANNELS - 1));
  assign pop       = data_rd && last_ch;
  assign push_req  = pcm_valid && enable;
  assign drop      = push_req && full && !pop && !flush;

  assign sample     = head_data[ch_idx*SAMPLE_W +: SAMPLE_W];
  assign sample_ext = 24'(sample);

  sample_fifo #(
    .WIDTH      (FRAME_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (pcm_data),
    .pop       (pop),
    .flush     (flush),
    .head_data (head_data),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    rdata_next = '0;
    if (access && !wb_we) begin
      case (wb_addr)
        REG_CTRL: begin
          rdata_next[CTRL_EN]    = enable;
          rdata_next[CTRL_OVF]   = overflow;
          rdata_next[CTRL_EMPTY] = empty;
          rdata_next[CTRL_FULL]  = full;
          rdata_next[31:16]      = 16'(level);
        end
        REG_DATA: begin
          if (!empty) begin
            rdata_next[23:0]       = sample_ext;
            rdata_next[27:24]      = ch_idx;
            rdata_next[DATA_VALID] = 1'b1;
          end
        end
        REG_THRESH: rdata_next[DEPTH_LOG2:0] = thresh;
        default:    rdata_next[15:0] = drops;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_ack   <= 1'b0;
      wb_rdata <= '0;
      irq      <= 1'b0;
      enable   <= 1'b0;
      overflow <= 1'b0;
      thresh   <= '0;
      drops    <= '0;
      ch_idx   <= '0;
    end else begin
      wb_ack   <= access;
      wb_rdata <= rdata_next;
      irq      <= enable && (thresh != '0) && (level >= thresh);

      if (ctrl_wr) enable <= wb_wdata[CTRL_EN];
      if (access && wb_we && (wb_addr == REG_THRESH)) thresh <= wb_wdata[DEPTH_LOG2:0];

      if (clear_ovf) begin
        overflow <= 1'b0;
        drops    <= '0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drops != 16'hFFFF) drops <= drops + 1'b1;
      end

      if (flush) begin
        ch_idx <= '0;
      end else if (data_rd) begin
        ch_idx <= last_ch ? 4'd0 : ch_idx + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dac_capture_wb.sv
// tb_dac_capture_wb: directed self-checking bench for dac_capture_wb (2 channels, 16-bit, depth 4).
`default_nettype none

module tb_dac_capture_wb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pcm_valid = 1'b0;
  logic [31:0] pcm_data = '0;
  logic [1:0]  wb_addr = '0;
  logic [31:0] wb_wdata = '0;
  logic        wb_we = 1'b0;
  logic        wb_cyc = 1'b0;
  logic [31:0] wb_rdata;
  logic        wb_ack;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  dac_capture_wb #(
    .CHANNELS   (2),
    .SAMPLE_W   (16),
    .DEPTH_LOG2 (2),
    .DW         (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pcm_valid (pcm_valid),
    .pcm_data  (pcm_data),
    .wb_addr   (wb_addr),
    .wb_wdata  (wb_wdata),
    .wb_we     (wb_we),
    .wb_cyc    (wb_cyc),
    .wb_rdata  (wb_rdata),
    .wb_ack    (wb_ack),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wb_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    wb_cyc = 1'b1; wb_we = 1'b0; wb_addr = a;
    @(posedge clk); #1;
    d = wb_ack ? wb_rdata : 32'hDEAD_DEAD;
    @(negedge clk);
    wb_cyc = 1'b0;
  endtask

  task automatic wb_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    wb_cyc = 1'b1; wb_we = 1'b1; wb_addr = a; wb_wdata = d;
    @(posedge clk); #1;
    @(negedge clk);
    wb_cyc = 1'b0; wb_we = 1'b0; wb_wdata = '0;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    @(negedge clk);
    pcm_valid = 1'b1; pcm_data = {r, l};
    @(negedge clk);
    pcm_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    n_cmp++; if (wb_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got=%b want=0", wb_ack); end
    n_cmp++; if (wb_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got=%h want=0", wb_rdata); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b want=0", irq); end
    wb_rd(2'd0, d);
    n_cmp++; if (d !== 32'h0000_0004) begin n_err++; $display("FAIL reset_ctrl got=%h want=00000004", d); end
    wb_rd(2'd2, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_thresh got=%h want=0", d); end
    wb_rd(2'd3, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_drops got=%h want=0", d); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    wb_wr(2'd0, 32'h1);
    push(16'h8001, 16'h1234);
    wb_rd(2'd1, d);
    n_cmp++; if (d !== 32'h80FF_8001) begin n_err++; $display("FAIL basic_ch0 got=%h want=80ff8001", d); end
    wb_rd(2'd1, d);
    n_cmp++; if (d !== 32'h8100_1234) begin n_err++; $display("FAIL basic_ch1 got=%h want=81001234", d); end
    wb_rd(2'd0, d);
    n_cmp++; if (d !== 32'h0000_0005) begin n_err++; $display("FAIL basic_ctrl got=%h want=00000005", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    for (int i = 0; i < 6; i++) push(16'h0010 + 16'(i), 16'hF000 + 16'(i));
    wb_rd(2'd0, d);
    n_cmp++; if (d !== 32'h0004_000B) begin n_err++; $display("FAIL ovf_ctrl got=%h want=0004000b", d); end
    wb_rd(2'd3, d);
    n_cmp++; if (d !== 32'h2) begin n_err++; $display("FAIL ovf_drops got=%h want=2", d); end
    for (int i = 0; i < 4; i++) begin
      wb_rd(2'd1, d);
      n_cmp++; if (d !== 32'h8000_0010 + 32'(i)) begin n_err++; $display("FAIL ovf_order_ch0[%0d] got=%h want=%h", i, d, 32'h8000_0010 + 32'(i)); end
      wb_rd(2'd1, d);
      n_cmp++; if (d !== 32'h81FF_F000 + 32'(i)) begin n_err++; $display("FAIL ovf_order_ch1[%0d] got=%h want=%h", i, d, 32'h81FF_F000 + 32'(i)); end
    end
    wb_wr(2'd0, 32'h3);
    wb_rd(2'd0, d);
    n_cmp++; if (d !== 32'h0000_0005) begin n_err++; $display("FAIL ovf_clear_ctrl got=%h want=00000005", d); end
    wb_rd(2'd3, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL ovf_clear_drops got=%h want=0", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    wb_wr(2'd2, 32'h3);
    wb_rd(2'd2, d);
    n_cmp++; if (d !== 32'h3) begin n_err++; $display("FAIL irq_thresh_rb got=%h want=3", d); end
    push(16'h0300, 16'h0400);
    push(16'h0301, 16'h0401);
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_below got=%b want=0", irq); end
    push(16'h0302, 16'h0402);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_latency got=%b want=0", irq); end
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_rise got=%b want=1", irq); end
    wb_rd(2'd1, d);
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_hold_midframe got=%b want=1", irq); end
    wb_rd(2'd1, d);
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_fall got=%b want=0", irq); end
    for (int i = 0; i < 4; i++) wb_rd(2'd1, d);
    wb_wr(2'd2, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int k = 0; k < 4; k++) push(16'h0100 + 16'(k), 16'h0200 + 16'(k));
    wb_rd(2'd1, d);
    n_cmp++; if (d !== 32'h8000_0100) begin n_err++; $display("FAIL b2b_first got=%h want=80000100", d); end
    @(negedge clk);
    wb_cyc = 1'b1; wb_we = 1'b0; wb_addr = 2'd1;
    pcm_valid = 1'b1; pcm_data = {16'h8000, 16'h7FFF};
    @(posedge clk); #1;
    d = wb_rdata;
    @(negedge clk);
    wb_cyc = 1'b0; pcm_valid = 1'b0;
    n_cmp++; if (d !== 32'h8100_0200) begin n_err++; $display("FAIL b2b_pop_word got=%h want=81000200", d); end
    wb_rd(2'd0, d);
    n_cmp++; if (d !== 32'h0004_0009) begin n_err++; $display("FAIL b2b_ctrl got=%h want=00040009", d); end
    wb_rd(2'd3, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL b2b_drops got=%h want=0", d); end
    for (int k = 1; k < 4; k++) begin
      wb_rd(2'd1, d);
      n_cmp++; if (d !== 32'h8000_0100 + 32'(k)) begin n_err++; $display("FAIL b2b_ch0[%0d] got=%h want=%h", k, d, 32'h8000_0100 + 32'(k)); end
      wb_rd(2'd1, d);
      n_cmp++; if (d !== 32'h8100_0200 + 32'(k)) begin n_err++; $display("FAIL b2b_ch1[%0d] got=%h want=%h", k, d, 32'h8100_0200 + 32'(k)); end
    end
    wb_rd(2'd1, d);
    n_cmp++; if (d !== 32'h8000_7FFF) begin n_err++; $display("FAIL b2b_last_ch0 got=%h want=80007fff", d); end
    wb_rd(2'd1, d);
    n_cmp++; if (d !== 32'h81FF_8000) begin n_err++; $display("FAIL b2b_last_ch1 got=%h want=81ff8000", d); end
    wb_rd(2'd0, d);
    n_cmp++; if (d !== 32'h0000_0005) begin n_err++; $display("FAIL b2b_drained got=%h want=00000005", d); end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    push(16'h0011, 16'h0022);
    wb_rd(2'd1, d);
    n_cmp++; if (d !== 32'h8000_0011) begin n_err++; $display("FAIL flush_pre got=%h want=80000011", d); end
    @(negedge clk);
    wb_cyc = 1'b1; wb_we = 1'b1; wb_addr = 2'd0; wb_wdata = 32'h5;
    pcm_valid = 1'b1; pcm_data = {16'h0077, 16'h0066};
    @(posedge clk); #1;
    @(negedge clk);
    wb_cyc = 1'b0; wb_we = 1'b0; wb_wdata = '0; pcm_valid = 1'b0;
    wb_rd(2'd0, d);
    n_cmp++; if (d !== 32'h0000_0005) begin n_err++; $display("FAIL flush_ctrl got=%h want=00000005", d); end
    wb_rd(2'd1, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL flush_data_empty got=%h want=0", d); end
    push(16'h0033, 16'h0044);
    wb_rd(2'd1, d);
    n_cmp++; if (d !== 32'h8000_0033) begin n_err++; $display("FAIL flush_chidx got=%h want=80000033", d); end
    wb_rd(2'd1, d);
    n_cmp++; if (d !== 32'h8100_0044) begin n_err++; $display("FAIL flush_after_ch1 got=%h want=81000044", d); end
  endtask

  task automatic test_disabled();
    logic [31:0] d;
    int acks;
    wb_wr(2'd0, 32'h0);
    for (int i = 0; i < 10; i++) push(16'(i), 16'(i));
    wb_rd(2'd0, d);
    n_cmp++; if (d !== 32'h0000_0004) begin n_err++; $display("FAIL dis_ctrl got=%h want=00000004", d); end
    wb_rd(2'd3, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL dis_drops got=%h want=0", d); end
    wb_wr(2'd0, 32'h1);
    push(16'h0055, 16'h0066);
    acks = 0;
    @(negedge clk);
    wb_cyc = 1'b1; wb_we = 1'b0; wb_addr = 2'd1;
    repeat (2) begin
      @(posedge clk); #1;
      if (wb_ack) acks++;
    end
    @(negedge clk);
    wb_cyc = 1'b0;
    @(posedge clk); #1;
    if (wb_ack) acks++;
    n_cmp++; if (acks !== 1) begin n_err++; $display("FAIL held_cyc_acks got=%0d want=1", acks); end
    wb_rd(2'd1, d);
    n_cmp++; if (d !== 32'h8100_0066) begin n_err++; $display("FAIL held_cyc_single_pop got=%h want=81000066", d); end
    wb_rd(2'd0, d);
    n_cmp++; if (d !== 32'h0000_0005) begin n_err++; $display("FAIL held_cyc_ctrl got=%h want=00000005", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_irq();
    test_back_to_back();
    test_flush();
    test_disabled();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
